// File: rtl/stream_checker.sv
// Compares a buffered expected-value stream against a DUT result stream under a bit mask,
// counting and reporting mismatches and flagging completion after a programmed number of beats.
module stream_checker #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic [CNT_W-1:0]          total_len,
  input  logic [DATA_W-1:0]         cmp_mask,
  input  logic                      exp_valid,
  output logic                      exp_ready,
  input  logic [DATA_W-1:0]         exp_data,
  input  logic                      act_valid,
  output logic                      act_ready,
  input  logic [DATA_W-1:0]         act_data,
  output logic                      busy,
  output logic                      done,
  output logic [CNT_W-1:0]          err_count,
  output logic                      mismatch_valid,
  output logic [CNT_W-1:0]          mismatch_index,
  output logic [DATA_W-1:0]         mismatch_exp,
  output logic [DATA_W-1:0]         mismatch_act,
  output logic                      first_err_valid,
  output logic [CNT_W-1:0]          first_err_index,
  output logic [$clog2(DEPTH):0]    exp_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  len, pushed, beat_idx;
  logic [DATA_W-1:0] mask, head;
  logic              full, empty, exp_hs, act_hs, mis;

  assign full      = (exp_level == LW'(DEPTH));
  assign empty     = (exp_level == '0);
  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign exp_ready = busy && !full && (pushed < len);
  assign act_ready = busy && !empty;
  assign exp_hs    = exp_valid && exp_ready;
  assign act_hs    = act_valid && act_ready;
  assign head      = mem[rd_ptr];
  assign mis       = |((act_data ^ head) & mask);

  always_ff @(posedge clock) begin
    if (exp_hs) mem[wr_ptr] <= exp_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      exp_level       <= '0;
      len             <= '0;
      mask            <= '0;
      pushed          <= '0;
      beat_idx        <= '0;
      err_count       <= '0;
      mismatch_valid  <= 1'b0;
      mismatch_index  <= '0;
      mismatch_exp    <= '0;
      mismatch_act    <= '0;
      first_err_valid <= 1'b0;
      first_err_index <= '0;
    end else begin
      mismatch_valid <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            len             <= total_len;
            mask            <= cmp_mask;
            pushed          <= '0;
            beat_idx        <= '0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_index <= '0;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            exp_level       <= '0;
            state           <= (total_len == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (exp_hs) begin
            wr_ptr <= wr_ptr + 1'b1;
            pushed <= pushed + 1'b1;
          end
          if (act_hs) begin
            rd_ptr   <= rd_ptr + 1'b1;
            beat_idx <= beat_idx + 1'b1;
            if (mis) begin
              mismatch_valid <= 1'b1;
              mismatch_index <= beat_idx;
              mismatch_exp   <= head;
              mismatch_act   <= act_data;
              if (err_count != '1) err_count <= err_count + 1'b1;
              if (!first_err_valid) begin
                first_err_valid <= 1'b1;
                first_err_index <= beat_idx;
              end
            end
            if (beat_idx == len - 1'b1) state <= DONE;
          end
          case ({exp_hs, act_hs})
            2'b10:   exp_level <= exp_level + 1'b1;
            2'b01:   exp_level <= exp_level - 1'b1;
            default: exp_level <= exp_level;
          endcase
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_checker.sv
// Self-checking bench for stream_checker: vector table of single-beat masked compares plus
// hand-written multi-beat sequences; mismatch reports are checked against a scoreboard queue.
module tb_stream_checker;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = 16;

  logic                     clock, reset, start;
  logic [CNT_W-1:0]         total_len;
  logic [DATA_W-1:0]        cmp_mask;
  logic                     exp_valid, exp_ready, act_valid, act_ready;
  logic [DATA_W-1:0]        exp_data, act_data;
  logic                     busy, done, mismatch_valid, first_err_valid;
  logic [CNT_W-1:0]         err_count, mismatch_index, first_err_index;
  logic [DATA_W-1:0]        mismatch_exp, mismatch_act;
  logic [$clog2(DEPTH):0]   exp_level;

  stream_checker #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .start(start), .total_len(total_len), .cmp_mask(cmp_mask),
    .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_data(exp_data),
    .act_valid(act_valid), .act_ready(act_ready), .act_data(act_data),
    .busy(busy), .done(done), .err_count(err_count),
    .mismatch_valid(mismatch_valid), .mismatch_index(mismatch_index),
    .mismatch_exp(mismatch_exp), .mismatch_act(mismatch_act),
    .first_err_valid(first_err_valid), .first_err_index(first_err_index),
    .exp_level(exp_level)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [CNT_W-1:0]  idx;
    logic [DATA_W-1:0] e;
    logic [DATA_W-1:0] a;
  } rep_t;

  typedef struct {
    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] e;
    logic [DATA_W-1:0] a;
    logic              mis;
  } vec_t;

  rep_t sb[$];
  vec_t tbl[7];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  always @(negedge clock) begin
    rep_t r;
    if (reset && mismatch_valid) begin
      if (sb.size() == 0) begin
        chk("spurious_mismatch", 64'(mismatch_index), 64'hFFFF_FFFF);
      end else begin
        r = sb.pop_front();
        chk("mismatch_index", 64'(mismatch_index), 64'(r.idx));
        chk("mismatch_exp", 64'(mismatch_exp), 64'(r.e));
        chk("mismatch_act", 64'(mismatch_act), 64'(r.a));
      end
    end
  end

  task automatic do_start(input logic [CNT_W-1:0] n, input logic [DATA_W-1:0] m);
    start = 1'b1; total_len = n; cmp_mask = m;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic push_exp(input logic [DATA_W-1:0] d);
    exp_valid = 1'b1; exp_data = d;
    #1;
    for (int i = 0; i < 64 && !exp_ready; i++) begin
      @(negedge clock); #1;
    end
    if (!exp_ready) begin
      chk("exp_timeout", 64'd0, 64'd1);
      exp_valid = 1'b0;
    end
    @(negedge clock);
  endtask

  task automatic push_act(input logic [CNT_W-1:0] idx, input logic [DATA_W-1:0] d,
                          input logic [DATA_W-1:0] e, input logic m);
    act_valid = 1'b1; act_data = d;
    #1;
    for (int i = 0; i < 64 && !act_ready; i++) begin
      @(negedge clock); #1;
    end
    if (!act_ready) begin
      chk("act_timeout", 64'd0, 64'd1);
      act_valid = 1'b0;
    end else if (m) begin
      sb.push_back('{idx, e, d});
    end
    @(negedge clock);
  endtask

  task automatic finish_run(input logic [CNT_W-1:0] errs, input logic fv, input logic [CNT_W-1:0] fi);
    @(negedge clock);
    chk("run_done", 64'(done), 64'd1);
    chk("run_busy", 64'(busy), 64'd0);
    chk("err_count", 64'(err_count), 64'(errs));
    chk("first_err_valid", 64'(first_err_valid), 64'(fv));
    if (fv) chk("first_err_index", 64'(first_err_index), 64'(fi));
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_err_count"}, 64'(err_count), 64'd0);
    chk({tag, "_mismatch_valid"}, 64'(mismatch_valid), 64'd0);
    chk({tag, "_mismatch_index"}, 64'(mismatch_index), 64'd0);
    chk({tag, "_mismatch_exp"}, 64'(mismatch_exp), 64'd0);
    chk({tag, "_mismatch_act"}, 64'(mismatch_act), 64'd0);
    chk({tag, "_first_err_valid"}, 64'(first_err_valid), 64'd0);
    chk({tag, "_first_err_index"}, 64'(first_err_index), 64'd0);
    chk({tag, "_exp_level"}, 64'(exp_level), 64'd0);
    chk({tag, "_exp_ready"}, 64'(exp_ready), 64'd0);
    chk({tag, "_act_ready"}, 64'(act_ready), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    longint t0;
    tbl[0] = '{32'hFFFF_FFFF, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0};
    tbl[1] = '{32'h0000_FFFF, 32'h1234_ABCD, 32'h9999_ABCD, 1'b0};
    tbl[2] = '{32'hFFFF_0000, 32'h1234_ABCD, 32'h9999_ABCD, 1'b1};
    tbl[3] = '{32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};
    tbl[4] = '{32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 1'b1};
    tbl[5] = '{32'h0000_0001, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b1};
    tbl[6] = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0};

    reset = 1'b0; start = 1'b0; total_len = '0; cmp_mask = '0;
    exp_valid = 1'b0; exp_data = '0; act_valid = 1'b0; act_data = '0;
    repeat (2) @(negedge clock);
    check_zero("reset");
    reset = 1'b1;
    @(negedge clock);

    // Matching stream, done exactly one cycle after the last act handshake
    do_start(16'd4, 32'hFFFF_FFFF);
    for (int i = 0; i < 4; i++) push_exp(32'(i + 1));
    exp_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) chk("done_before_last", 64'(done), 64'd0);
      push_act(CNT_W'(i), 32'(i + 1), 32'(i + 1), 1'b0);
    end
    act_valid = 1'b0;
    chk("done_after_last", 64'(done), 64'd1);
    finish_run(16'd0, 1'b0, 16'd0);

    // Single mismatch on beat 2
    do_start(16'd4, 32'hFFFF_FFFF);
    for (int i = 0; i < 4; i++) push_exp(32'(i + 1));
    exp_valid = 1'b0;
    for (int i = 0; i < 4; i++)
      push_act(CNT_W'(i), (i == 2) ? 32'hDEAD_BEEF : 32'(i + 1), 32'(i + 1), i == 2);
    act_valid = 1'b0;
    finish_run(16'd1, 1'b1, 16'd2);

    // Masked single-beat runs, each restarted from DONE
    for (int i = 0; i < 7; i++) begin
      do_start(16'd1, tbl[i].mask);
      chk("restart_busy", 64'(busy), 64'd1);
      chk("restart_done", 64'(done), 64'd0);
      push_exp(tbl[i].e);
      exp_valid = 1'b0;
      push_act(16'd0, tbl[i].a, tbl[i].e, tbl[i].mis);
      act_valid = 1'b0;
      finish_run(16'(tbl[i].mis), tbl[i].mis, 16'd0);
    end

    // Full FIFO backpressure, then drain at one beat per cycle with push/pop overlap
    do_start(16'd10, 32'hFFFF_FFFF);
    for (int i = 0; i < 8; i++) push_exp(32'(i + 1));
    exp_data = 32'd9;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("full_exp_ready", 64'(exp_ready), 64'd0);
      chk("full_exp_level", 64'(exp_level), 64'd8);
      @(negedge clock);
    end
    fork
      begin
        push_exp(32'd9);
        push_exp(32'd10);
        exp_valid = 1'b0;
      end
      begin
        t0 = $time;
        for (int i = 0; i < 10; i++) push_act(CNT_W'(i), 32'(i + 1), 32'(i + 1), 1'b0);
        act_valid = 1'b0;
        chk("drain_cycles", 64'(($time - t0) / 10), 64'd10);
      end
    join
    finish_run(16'd0, 1'b0, 16'd0);

    // Zero-length run goes straight to DONE
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("len0_pre_done", 64'(done), 64'd0);
    do_start(16'd0, 32'hFFFF_FFFF);
    chk("len0_done", 64'(done), 64'd1);
    chk("len0_busy", 64'(busy), 64'd0);
    chk("len0_err_count", 64'(err_count), 64'd0);

    // Empty FIFO blocks act, no bypass; only total_len expected beats accepted
    do_start(16'd3, 32'hFFFF_FFFF);
    act_valid = 1'b1; act_data = 32'h11;
    #1 chk("empty_act_ready", 64'(act_ready), 64'd0);
    @(negedge clock);
    exp_valid = 1'b1; exp_data = 32'h11;
    #1 chk("no_bypass_act_ready", 64'(act_ready), 64'd0);
    @(negedge clock);
    act_valid = 1'b0;
    push_exp(32'h22);
    push_exp(32'h33);
    exp_data = 32'h44;
    #1;
    chk("len3_exp_ready", 64'(exp_ready), 64'd0);
    chk("len3_exp_level", 64'(exp_level), 64'd3);
    @(negedge clock);
    #1 chk("len3_exp_ready_hold", 64'(exp_ready), 64'd0);
    @(negedge clock);
    exp_valid = 1'b0;
    push_act(16'd0, 32'h11, 32'h11, 1'b0);
    push_act(16'd1, 32'h22, 32'h22, 1'b0);
    push_act(16'd2, 32'h33, 32'h33, 1'b0);
    act_valid = 1'b0;
    finish_run(16'd0, 1'b0, 16'd0);

    // Reset mid-run aborts silently, then a fresh run completes clean
    do_start(16'd4, 32'hFFFF_FFFF);
    for (int i = 0; i < 4; i++) push_exp(32'(i + 1));
    exp_valid = 1'b0;
    push_act(16'd0, 32'h0000_0BAD, 32'd1, 1'b1);
    act_valid = 1'b0;
    #2 reset = 1'b0;
    #1 check_zero("midrun_reset");
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    chk("post_reset_done", 64'(done), 64'd0);
    chk("post_reset_busy", 64'(busy), 64'd0);
    do_start(16'd2, 32'hFFFF_FFFF);
    push_exp(32'd5);
    push_exp(32'd6);
    exp_valid = 1'b0;
    push_act(16'd0, 32'd5, 32'd5, 1'b0);
    push_act(16'd1, 32'd6, 32'd6, 1'b0);
    act_valid = 1'b0;
    finish_run(16'd0, 1'b0, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_checker.md
Name: stream_checker

Overview:
- Synthesizable, parametrised successor to the file-driven result comparison.
- Buffers an expected-value stream in an internal FIFO and compares it, beat by beat, against a DUT result stream under a bit mask.
- Counts mismatches, reports each one, captures the first one, and signals done after a programmed number of beats.
- Sits between a stimulus/expected-value source and a DUT output port, in simulation or on FPGA.

Parameters:
- DATA_W, 32, width of the expected and actual data.
- DEPTH, 8, expected-FIFO entries; power of 2, at least 2.
- CNT_W, 16, width of the beat counter, the error counter and the length input.

Ports:
- clock  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low.
- start  in  1  pulse; starts a run using total_len.
- total_len  in  CNT_W  number of beats to compare; sampled on start.
- cmp_mask  in  DATA_W  1 = bit is compared; sampled on start.
- exp_valid  in  1  expected beat valid.
- exp_ready  out  1  expected beat accepted.
- exp_data  in  DATA_W  expected value.
- act_valid  in  1  actual (DUT) beat valid.
- act_ready  out  1  actual beat accepted.
- act_data  in  DATA_W  DUT result.
- busy  out  1  run in progress.
- done  out  1  run complete; held until the next start.
- err_count  out  CNT_W  mismatches this run; saturates at all-ones.
- mismatch_valid  out  1  one-cycle pulse per mismatch.
- mismatch_index  out  CNT_W  beat index of the reported mismatch, 0-based.
- mismatch_exp  out  DATA_W  expected value of the reported mismatch.
- mismatch_act  out  DATA_W  actual value of the reported mismatch.
- first_err_valid  out  1  at least one mismatch this run.
- first_err_index  out  CNT_W  index of the first mismatch.
- exp_level  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
Reset (reset low, asynchronous):
- State goes to IDLE and the FIFO is emptied.
- All outputs are 0; the exception is mismatch_exp/act, which are don't-care but driven 0.
- Reset mid-run aborts the run silently: no done, and counters are cleared.

State machine, IDLE / RUN / DONE:
- IDLE + start, total_len != 0: latch len and mask; clear err_count, beat index, pushed count and first_err_*; flush the FIFO; go to RUN.
- IDLE + start, total_len == 0: go directly to DONE, with done=1 the next cycle and err_count=0.
- RUN: start is ignored.
- RUN: after the act handshake for beat len-1, go to DONE on the next edge.
- DONE + start: same as from IDLE, i.e. restart; done drops the cycle after start.
- busy = (state == RUN); done = (state == DONE).

Expected side:
- exp_ready = RUN && !full && (pushed < len).
- Beats beyond len are never accepted.

Actual side:
- act_ready = RUN && !empty.
- No bypass: an empty FIFO blocks act even if exp_valid is high in the same cycle.

FIFO:
- Push and pop in the same cycle are both legal when neither full nor empty; the level is unchanged.
- Pointers wrap modulo DEPTH.

Compare, on the act handshake:
- mismatch = ((act_data ^ fifo_head) & mask) != 0.
- Results are registered, so mismatch_valid/index/exp/act appear 1 cycle after the handshake.
- err_count increments in that same cycle; it saturates at 2^CNT_W-1 and never wraps.
- first_err_* is set only on the first mismatch of the run.
- The last beat's report coincides with the first DONE cycle.

Throughput: 1 beat/cycle when both streams are continuously valid and the FIFO is non-empty.

Handshake rule: valid must not depend on ready; data is stable while valid && !ready.

Test Plan:
- Matching stream: start with total_len=4, mask=FFFFFFFF, 4 expected then 4 actual beats 00000001, 00000002, 00000003, 00000004 → err_count=0, first_err_valid=0, done=1 one cycle after the 4th act handshake.
- Mismatch: act beat 2 = DEADBEEF vs expected 00000003, total_len=4 → a single mismatch_valid pulse with index=2, exp=00000003, act=DEADBEEF; err_count=1; first_err_index=2.
- Masked compare: mask=0000FFFF, exp=1234ABCD, act=9999ABCD → no mismatch; with mask=FFFF0000 → mismatch at that index.
- Backpressure and full FIFO: DEPTH=8, 10 expected beats offered with act idle → exp_ready drops after 8 and exp_level=8. Releasing act then drains all beats with simultaneous push/pop, and all 10 compare correctly.
- Boundary: total_len=0 → DONE next cycle. total_len=3 with 5 expected beats offered → only 3 accepted. An act beat offered while the FIFO is empty → act_ready=0.
- Reset and restart: drive reset low after beat 1 of 4 → all outputs 0 and no done. A new start with total_len=2 then completes with clean counters. A start asserted while in DONE restarts the run.
